// File: rtl/jt10_adpcm_pkg.sv
// jt10_adpcm_pkg: shared constants and helpers for the
// multi-channel ADPCM-A ROM address sequencer.
package jt10_adpcm_pkg;

   localparam logic NIB_HI = 1'b1;
   localparam logic NIB_LO = 1'b0;

   function automatic int slot_w(input int ch);
      return (ch < 2) ? 1 : $clog2(ch);
   endfunction

   // all-ones pattern for the byte-address bits below start/end
   function automatic logic [31:0] end_lo_mask(input int lw);
      return (32'd1 << lw) - 32'd1;
   endfunction

endpackage

// File: rtl/jt10_adpcm_chnext.sv
// jt10_adpcm_chnext: next state of the channel owning the
// current slot (key-off, key-on reload, or one nibble step).
module jt10_adpcm_chnext
   import jt10_adpcm_pkg::*;
#(
   parameter int AW = 20,
   parameter int RW = 12
) (
   input  logic          pend_on,
   input  logic          pend_off,
   input  logic          active,
   input  logic          sel,
   input  logic          loop,
   input  logic [AW-1:0] addr,
   input  logic [RW-1:0] st,
   input  logic [RW-1:0] ed,
   output logic [AW-1:0] addr_nx,
   output logic          sel_nx,
   output logic          act_nx,
   output logic          fetch,
   output logic          eos_set,
   output logic          eos_clr
);

   localparam int LW = AW - RW;
   localparam logic [LW-1:0] LO = LW'(end_lo_mask(LW));

   logic [AW-1:0] st_addr;
   logic          at_end;
   logic          do_off;
   logic          do_on;
   logic          do_play;

   assign st_addr = {st, {LW{1'b0}}};
   assign at_end  = (addr == {ed, LO}) && (sel == NIB_LO);

   assign do_off  = pend_off;
   assign do_on   = pend_on & ~pend_off;
   assign do_play = active & ~pend_on & ~pend_off;

   always_comb begin
      addr_nx = addr;
      sel_nx  = sel;
      act_nx  = active;
      fetch   = 1'b0;
      eos_set = 1'b0;
      eos_clr = 1'b0;
      unique case (1'b1)
         do_off: begin
            act_nx = 1'b0;
         end
         do_on: begin
            addr_nx = st_addr;
            sel_nx  = NIB_HI;
            act_nx  = 1'b1;
            eos_clr = 1'b1;
         end
         do_play: begin
            fetch  = 1'b1;
            sel_nx = ~sel;
            if (sel == NIB_LO)
               addr_nx = addr + AW'(1);
            // last nibble: stop, or rewind when looping
            if (at_end) begin
               eos_set = 1'b1;
               act_nx  = loop;
               if (loop) begin
                  addr_nx = st_addr;
                  sel_nx  = NIB_HI;
               end
            end
         end
         default: begin
         end
      endcase
   end

endmodule

// File: rtl/jt10_adpcm_seqn.sv
// jt10_adpcm_seqn: time-multiplexed ADPCM-A ROM sequencer.
// Define JT10_ADPCM_LOOP_EN to add per-channel looping (loop_en).
module jt10_adpcm_seqn
   import jt10_adpcm_pkg::*;
#(
   parameter  int CH  = 6,
   parameter  int AW  = 20,
   parameter  int RW  = 12,
   localparam int CHW = slot_w(CH)
) (
   input  logic           rst_n,
   input  logic           clk,
   input  logic           cen,
   input  logic [CHW-1:0] wr_ch,
   input  logic           start_wr,
   input  logic           end_wr,
   input  logic [RW-1:0]  addr_in,
`ifdef JT10_ADPCM_LOOP_EN
   input  logic [CH-1:0]  loop_en,
`endif
   input  logic [CH-1:0]  key_on,
   input  logic [CH-1:0]  key_off,
   input  logic [CH-1:0]  flag_clr,
   output logic [AW-1:0]  rom_addr,
   output logic           roe_n,
   output logic           nibble_sel,
   output logic [CHW-1:0] slot,
   output logic [CH-1:0]  active,
   output logic [CH-1:0]  eos_flag
);

   logic [RW-1:0]  st_r   [CH];
   logic [RW-1:0]  ed_r   [CH];
   logic [AW-1:0]  addr_r [CH];
   logic [CH-1:0]  sel_r;
   logic [CH-1:0]  pend_on;
   logic [CH-1:0]  pend_off;
   logic [CH-1:0]  loop_v;
   logic [CH-1:0]  svc;
   logic [CHW-1:0] s;

   logic [AW-1:0]  nx_addr;
   logic           nx_sel;
   logic           nx_act;
   logic           nx_fetch;
   logic           nx_eos_set;
   logic           nx_eos_clr;

`ifdef JT10_ADPCM_LOOP_EN
   assign loop_v = loop_en;
`else
   assign loop_v = '0;
`endif

   always_comb begin
      svc = '0;
      for (int i = 0; i < CH; i++)
         svc[i] = cen && (s == CHW'(i));
   end

   jt10_adpcm_chnext #(
      .AW (AW),
      .RW (RW)
   ) u_next (
      .pend_on  (pend_on[s]),
      .pend_off (pend_off[s]),
      .active   (active[s]),
      .sel      (sel_r[s]),
      .loop     (loop_v[s]),
      .addr     (addr_r[s]),
      .st       (st_r[s]),
      .ed       (ed_r[s]),
      .addr_nx  (nx_addr),
      .sel_nx   (nx_sel),
      .act_nx   (nx_act),
      .fetch    (nx_fetch),
      .eos_set  (nx_eos_set),
      .eos_clr  (nx_eos_clr)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s          <= '0;
         slot       <= '0;
         rom_addr   <= '0;
         roe_n      <= 1'b1;
         nibble_sel <= NIB_LO;
         active     <= '0;
         eos_flag   <= '0;
         sel_r      <= '0;
         pend_on    <= '0;
         pend_off   <= '0;
         for (int i = 0; i < CH; i++) begin
            st_r[i]   <= '0;
            ed_r[i]   <= '0;
            addr_r[i] <= '0;
         end
      end else begin
         for (int i = 0; i < CH; i++) begin
            if (start_wr && wr_ch == CHW'(i))
               st_r[i] <= addr_in;
            if (end_wr && wr_ch == CHW'(i))
               ed_r[i] <= addr_in;
            // a fresh key event outranks the slot consuming the old one
            if (key_off[i]) begin
               pend_off[i] <= 1'b1;
               pend_on[i]  <= 1'b0;
            end else if (key_on[i]) begin
               pend_on[i]  <= 1'b1;
               pend_off[i] <= 1'b0;
            end else if (svc[i]) begin
               pend_on[i]  <= 1'b0;
               pend_off[i] <= 1'b0;
            end
            if (svc[i]) begin
               addr_r[i] <= nx_addr;
               sel_r[i]  <= nx_sel;
               active[i] <= nx_act;
            end
            if (svc[i] && nx_eos_set)
               eos_flag[i] <= 1'b1;
            else if ((svc[i] && nx_eos_clr) || flag_clr[i])
               eos_flag[i] <= 1'b0;
         end
         if (cen) begin
            s     <= (s == CHW'(CH-1)) ? '0 : s + CHW'(1);
            slot  <= s;
            roe_n <= ~nx_fetch;
            if (nx_fetch) begin
               rom_addr   <= addr_r[s];
               nibble_sel <= sel_r[s];
            end
         end
      end
   end

endmodule

// File: tb/tb_jt10_adpcm_seqn.sv
// tb_jt10_adpcm_seqn: directed vectors plus randomized traffic
// checked against a nibble-position model of each channel.
module tb_jt10_adpcm_seqn;

   localparam int CH   = 6;
   localparam int AW   = 20;
   localparam int RW   = 12;
   localparam int CHW  = 3;
   localparam int LW   = AW - RW;
   localparam int PMOD = 1 << (AW + 1);

   logic           rst_n;
   logic           clk;
   logic           cen;
   logic [CHW-1:0] wr_ch;
   logic           start_wr;
   logic           end_wr;
   logic [RW-1:0]  addr_in;
   logic [CH-1:0]  key_on;
   logic [CH-1:0]  key_off;
   logic [CH-1:0]  flag_clr;
   logic [CH-1:0]  loop_en;
   logic [AW-1:0]  rom_addr;
   logic           roe_n;
   logic           nibble_sel;
   logic [CHW-1:0] slot;
   logic [CH-1:0]  active;
   logic [CH-1:0]  eos_flag;

   int checks = 0;
   int errors = 0;
   int bs;

   jt10_adpcm_seqn dut (
      .rst_n      (rst_n),
      .clk        (clk),
      .cen        (cen),
      .wr_ch      (wr_ch),
      .start_wr   (start_wr),
      .end_wr     (end_wr),
      .addr_in    (addr_in),
`ifdef JT10_ADPCM_LOOP_EN
      .loop_en    (loop_en),
`endif
      .key_on     (key_on),
      .key_off    (key_off),
      .flag_clr   (flag_clr),
      .rom_addr   (rom_addr),
      .roe_n      (roe_n),
      .nibble_sel (nibble_sel),
      .slot       (slot),
      .active     (active),
      .eos_flag   (eos_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // model: each channel tracked as a nibble position p,
   // byte = p/2, high nibble first (p even)
   int            m_p  [CH];
   int            m_st [CH];
   int            m_ed [CH];
   int            m_s;
   int            m_rom;
   logic [CH-1:0] m_act;
   logic [CH-1:0] m_eos;
   logic [CH-1:0] m_pon;
   logic [CH-1:0] m_poff;
   logic [2:0]    m_slot;
   logic          m_roe;
   logic          m_nib;

   always @(posedge clk or negedge rst_n) begin : model
      int   c;
      logic eset;
      logic eclr;
      if (!rst_n) begin
         for (int i = 0; i < CH; i++) begin
            m_p[i] = 0; m_st[i] = 0; m_ed[i] = 0;
         end
         m_s = 0; m_rom = 0; m_slot = 0;
         m_roe = 1; m_nib = 0;
         m_act = 0; m_eos = 0; m_pon = 0; m_poff = 0;
      end else begin
         c = m_s; eset = 0; eclr = 0;
         if (cen) begin
            m_slot = 3'(c);
            m_roe  = 1;
            if (m_poff[c]) begin
               m_act[c] = 0;
            end else if (m_pon[c]) begin
               m_p[c] = m_st[c] * (1 << (LW + 1));
               m_act[c] = 1;
               eclr = 1;
            end else if (m_act[c]) begin
               m_rom = m_p[c] / 2;
               m_nib = (m_p[c] % 2 == 0);
               m_roe = 0;
               if (m_p[c] == ((m_ed[c] + 1) * (1 << LW) - 1) * 2 + 1) begin
                  eset = 1;
                  if (loop_en[c]) m_p[c] = m_st[c] * (1 << (LW + 1));
                  else m_act[c] = 0;
               end else begin
                  m_p[c] = (m_p[c] + 1) % PMOD;
               end
            end
            m_s = (c + 1) % CH;
         end
         m_eos = m_eos & ~flag_clr;
         if (eset) m_eos[c] = 1;
         if (eclr) m_eos[c] = 0;
         for (int i = 0; i < CH; i++) begin
            if (key_off[i]) begin
               m_poff[i] = 1; m_pon[i] = 0;
            end else if (key_on[i]) begin
               m_pon[i] = 1; m_poff[i] = 0;
            end else if (cen && i == c) begin
               m_pon[i] = 0; m_poff[i] = 0;
            end
         end
         if (start_wr) m_st[wr_ch] = int'(addr_in);
         if (end_wr) m_ed[wr_ch] = int'(addr_in);
      end
   end

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         checks++;
         if ({slot, roe_n, nibble_sel, rom_addr, active, eos_flag} !==
             {m_slot, m_roe, m_nib, AW'(m_rom), m_act, m_eos}) begin
            errors++;
            $display("FAIL scoreboard t=%0t got slot=%0d roe_n=%b nib=%b addr=%h act=%b eos=%b want slot=%0d roe_n=%b nib=%b addr=%h act=%b eos=%b",
                     $time, slot, roe_n, nibble_sel, rom_addr, active, eos_flag,
                     m_slot, m_roe, m_nib, AW'(m_rom), m_act, m_eos);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic step(input logic c);
      cen = c;
      @(negedge clk);
      if (c) bs = (bs + 1) % CH;
      cen = 0; key_on = 0; key_off = 0; flag_clr = 0;
      start_wr = 0; end_wr = 0;
   endtask

   task automatic service(input int ch, input logic [CH-1:0] fc);
      while (bs != ch) step(1);
      flag_clr = fc;
      step(1);
   endtask

   task automatic wr(input int ch, input logic [RW-1:0] sv, input logic [RW-1:0] ev);
      wr_ch = CHW'(ch);
      addr_in = sv; start_wr = 1; step(0);
      addr_in = ev; end_wr = 1; step(0);
   endtask

   typedef struct {
      int             ncen;
      logic [CH-1:0]  kon;
      logic [CHW-1:0] slot;
      logic           roe;
      logic [AW-1:0]  addr;
      logic           nib;
      logic [CH-1:0]  act;
   } vec_t;

   vec_t tbl[$];

   initial begin
      for (int k = 0; k < 12; k++)
         tbl.push_back('{1, 6'b0, CHW'(k % 6), 1'b1, 20'h0, 1'b0, 6'b0});
      tbl.push_back('{3, 6'b000100, 3'd2, 1'b1, 20'h00000, 1'b0, 6'b000100});
      tbl.push_back('{6, 6'b000000, 3'd2, 1'b0, 20'h00100, 1'b1, 6'b000100});
      tbl.push_back('{6, 6'b000000, 3'd2, 1'b0, 20'h00100, 1'b0, 6'b000100});
      tbl.push_back('{6, 6'b000000, 3'd2, 1'b0, 20'h00101, 1'b1, 6'b000100});

      rst_n = 0; cen = 0; wr_ch = 0; start_wr = 0; end_wr = 0;
      addr_in = 0; key_on = 0; key_off = 0; flag_clr = 0; loop_en = 0;
      repeat (3) @(negedge clk);
      chk("rst rom_addr", rom_addr, 0);
      chk("rst roe_n", roe_n, 1);
      chk("rst nibble_sel", nibble_sel, 0);
      chk("rst slot", slot, 0);
      chk("rst active", active, 0);
      chk("rst eos_flag", eos_flag, 0);
      rst_n = 1; bs = 0;

      wr(2, 12'h001, 12'h001);
      foreach (tbl[j]) begin
         key_on = tbl[j].kon;
         for (int n = 0; n < tbl[j].ncen; n++) step(1);
         chk($sformatf("vec%0d slot", j), slot, tbl[j].slot);
         chk($sformatf("vec%0d roe_n", j), roe_n, tbl[j].roe);
         chk($sformatf("vec%0d rom_addr", j), rom_addr, tbl[j].addr);
         chk($sformatf("vec%0d nibble_sel", j), nibble_sel, tbl[j].nib);
         chk($sformatf("vec%0d active", j), active, tbl[j].act);
      end

      // ch2 run-out with flag_clr colliding on the end event
      repeat (508 * 6) step(1);
      chk("ch2 pre-end addr", rom_addr, 20'h001FF);
      chk("ch2 pre-end nib", nibble_sel, 1);
      service(2, 6'b000100);
      chk("ch2 end addr", rom_addr, 20'h001FF);
      chk("ch2 end nib", nibble_sel, 0);
      chk("ch2 end active", active[2], 0);
      chk("ch2 end eos set wins", eos_flag[2], 1);
      flag_clr = 6'b000100; step(0);
      chk("ch2 eos cleared", eos_flag[2], 0);

      // ch4: simultaneous on/off, then on alone
      wr(4, 12'h0AB, 12'hFFF);
      key_on = 6'b010000; key_off = 6'b010000; step(0);
      service(4, 0);
      chk("ch4 on+off active", active[4], 0);
      key_on = 6'b010000; step(0);
      service(4, 0);
      chk("ch4 load active", active[4], 1);
      chk("ch4 load roe_n", roe_n, 1);
      service(4, 0);
      chk("ch4 first addr", rom_addr, 20'h0AB00);
      chk("ch4 first nib", nibble_sel, 1);
      chk("ch4 first slot", slot, 4);
      key_off = 6'b010000; step(0);

      // ch3: start above end, plays through the address wrap
      wr(3, 12'hFFF, 12'h000);
      key_on = 6'b001000; step(0);
      service(3, 0);
      repeat (511) service(3, 0);
      service(3, 0);
      chk("wrap top addr", rom_addr, 20'hFFFFF);
      chk("wrap top nib", nibble_sel, 0);
      service(3, 0);
      chk("wrap zero addr", rom_addr, 20'h00000);
      chk("wrap zero nib", nibble_sel, 1);
      repeat (510) service(3, 0);
      service(3, 0);
      chk("wrap end addr", rom_addr, 20'h000FF);
      chk("wrap end nib", nibble_sel, 0);
      chk("wrap end active", active[3], 0);
      chk("wrap end eos", eos_flag[3], 1);
      key_on = 6'b001000; step(0);
      service(3, 0);
      chk("ch3 restart eos", eos_flag[3], 0);
      chk("ch3 restart active", active[3], 1);
      service(3, 0);
      chk("ch3 restart addr", rom_addr, 20'hFFF00);
      chk("ch3 restart nib", nibble_sel, 1);

`ifdef JT10_ADPCM_LOOP_EN
      wr(1, 12'h010, 12'h010);
      loop_en = 6'b000010;
      key_on = 6'b000010; step(0);
      service(1, 0);
      repeat (511) service(1, 0);
      service(1, 0);
      chk("loop end addr", rom_addr, 20'h010FF);
      chk("loop end eos", eos_flag[1], 1);
      chk("loop end active", active[1], 1);
      service(1, 0);
      chk("loop reload addr", rom_addr, 20'h01000);
      chk("loop reload nib", nibble_sel, 1);
      loop_en = 0;
`endif

      // randomized traffic, short sample spans so ends occur
      key_off = '1; step(0);
      for (int i = 0; i < CH; i++) begin
         logic [RW-1:0] sv;
         sv = RW'($urandom);
         wr(i, sv, sv + RW'($urandom_range(0, 1)));
      end
      key_on = '1; step(0);
      for (int t = 0; t < 30000; t++) begin
         cen = 1'($urandom_range(0, 1));
         for (int i = 0; i < CH; i++) begin
            key_on[i]   = ($urandom_range(0, 2999) == 0);
            key_off[i]  = ($urandom_range(0, 5999) == 0);
            flag_clr[i] = ($urandom_range(0, 15) == 0);
         end
         start_wr = ($urandom_range(0, 499) == 0);
         end_wr   = ($urandom_range(0, 499) == 0);
         wr_ch    = CHW'($urandom_range(0, CH - 1));
         addr_in  = RW'($urandom);
`ifdef JT10_ADPCM_LOOP_EN
         if ($urandom_range(0, 999) == 0) loop_en = CH'($urandom);
`endif
         @(negedge clk);
      end
      cen = 0; key_on = 0; key_off = 0; flag_clr = 0;
      start_wr = 0; end_wr = 0;

      // reset mid-play with pending key-ons outstanding
      key_on = '1; step(0);
      #2 rst_n = 0;
      #1;
      chk("midrst rom_addr", rom_addr, 0);
      chk("midrst roe_n", roe_n, 1);
      chk("midrst nibble_sel", nibble_sel, 0);
      chk("midrst slot", slot, 0);
      chk("midrst active", active, 0);
      chk("midrst eos_flag", eos_flag, 0);
      @(negedge clk);
      rst_n = 1; bs = 0;
      repeat (6) step(1);
      chk("midrst pend lost", active, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
